// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: two requester ports plus the ram_storage bus of the RAM access arbiter
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0, rw0, gnt0, done0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1, rw1, gnt1, done1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata;
  logic              ram_cs, ram_rw, busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_data_out,
    output gnt0, done0, gnt1, done1, rdata, ram_cs, ram_rw, ram_addr, ram_data_in, busy
  );
  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_data_out,
    input  gnt0, done0, gnt1, done1, rdata, ram_cs, ram_rw, ram_addr, ram_data_in, busy
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one RAM between two requesters, sequencing each access as setup/strobe/hold
module ram_access_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int CS_CYCLES   = 2,
  parameter int ROUND_ROBIN = 1
) (
  input logic clk,
  input logic reset,
  ram_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam logic [3:0] CS_LAST = 4'(CS_CYCLES - 1);
  localparam logic RR = ROUND_ROBIN != 0;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_sel, r_last, r_gnt0, r_gnt1, r_done0, r_done1, r_cs, r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_req, w_pick1;
  assign w_req = bus.req0 | bus.req1;
  // on conflict port 1 wins only under round-robin when port 0 was served last
  assign w_pick1 = bus.req1 & (~bus.req0 | (RR & ~r_last));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_cs    <= 1'b0;
      r_rw    <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if (w_req) begin
            r_state <= SETUP;
            r_sel   <= w_pick1;
            r_last  <= w_pick1;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_rw    <= w_pick1 ? bus.rw1 : bus.rw0;
            r_addr  <= w_pick1 ? bus.addr1 : bus.addr0;
            r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          r_state <= STROBE;
          r_cs    <= 1'b1;
          r_cnt   <= CS_LAST;
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= HOLD;
            r_cs    <= 1'b0;
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
            if (r_rw) r_rdata <= bus.ram_data_out;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end
  assign bus.gnt0        = r_gnt0;
  assign bus.gnt1        = r_gnt1;
  assign bus.done0       = r_done0;
  assign bus.done1       = r_done1;
  assign bus.rdata       = r_rdata;
  assign bus.ram_cs      = r_cs;
  assign bus.ram_rw      = r_rw;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_data_in = r_wdata;
  assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and randomized checks of four arbiter configurations against a transaction-level model
module tb_ram_access_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic       req0_v [4], rw0_v [4], req1_v [4], rw1_v [4];
  logic [7:0] addr0_v [4], wdata0_v [4], addr1_v [4], wdata1_v [4];
  logic       o_gnt0 [4], o_gnt1 [4], o_done0 [4], o_done1 [4], o_cs [4], o_rw [4], o_busy [4];
  logic [7:0] o_addr [4], o_din [4], o_rdata [4];
  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  // instance 0: CS=2 RR=1, 1: CS=2 RR=0, 2: CS=1 RR=1, 3: CS=15 RR=1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_access_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    ram_access_arbiter #(
      .ADDR_W(8), .DATA_W(8),
      .CS_CYCLES(g == 3 ? 15 : g == 2 ? 1 : 2),
      .ROUND_ROBIN(g == 1 ? 0 : 1)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    always @(posedge clk) if (bus.ram_cs && !bus.ram_rw) mem[bus.ram_addr] <= bus.ram_data_in;
    assign bus.ram_data_out = mem[bus.ram_addr];
    assign bus.req0   = req0_v[g];
    assign bus.rw0    = rw0_v[g];
    assign bus.addr0  = addr0_v[g];
    assign bus.wdata0 = wdata0_v[g];
    assign bus.req1   = req1_v[g];
    assign bus.rw1    = rw1_v[g];
    assign bus.addr1  = addr1_v[g];
    assign bus.wdata1 = wdata1_v[g];
    assign o_gnt0[g]  = bus.gnt0;
    assign o_gnt1[g]  = bus.gnt1;
    assign o_done0[g] = bus.done0;
    assign o_done1[g] = bus.done1;
    assign o_cs[g]    = bus.ram_cs;
    assign o_rw[g]    = bus.ram_rw;
    assign o_busy[g]  = bus.busy;
    assign o_addr[g]  = bus.ram_addr;
    assign o_din[g]   = bus.ram_data_in;
    assign o_rdata[g] = bus.rdata;
  end
  // transaction model: an access granted in cycle g strobes in g+1..g+CS and completes in g+CS+1
  logic       m_act [4], m_port [4], m_last [4], m_rw [4];
  int         m_g [4];
  logic [7:0] m_addr [4], m_data [4], m_rdata [4];
  logic [7:0] m_mem [4][256];
  function automatic int cs_of(input int k);
    return k == 3 ? 15 : k == 2 ? 1 : 2;
  endfunction
  function automatic logic gnt_now(input int k, input logic p);
    return m_act[k] && cyc == m_g[k] && m_port[k] == p;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset(input int k);
    m_act[k] = 1'b0; m_port[k] = 1'b0; m_last[k] = 1'b1; m_rw[k] = 1'b1;
    m_g[k] = 0; m_addr[k] = 8'h00; m_data[k] = 8'h00; m_rdata[k] = 8'h00;
  endtask
  task automatic model_advance(input int k);
    logic p;
    if (!m_act[k] || cyc - 1 - m_g[k] == cs_of(k) + 1) begin
      if (req0_v[k] || req1_v[k]) begin
        p = (req0_v[k] && req1_v[k]) ? (k != 1 && !m_last[k]) : req1_v[k];
        m_act[k] = 1'b1; m_g[k] = cyc; m_port[k] = p; m_last[k] = p;
        m_rw[k]   = p ? rw1_v[k] : rw0_v[k];
        m_addr[k] = p ? addr1_v[k] : addr0_v[k];
        m_data[k] = p ? wdata1_v[k] : wdata0_v[k];
      end else m_act[k] = 1'b0;
    end
    if (m_act[k] && cyc - m_g[k] == cs_of(k) + 1) begin
      if (m_rw[k]) m_rdata[k] = m_mem[k][m_addr[k]];
      else m_mem[k][m_addr[k]] = m_data[k];
    end
  endtask
  task automatic compare(input int k);
    int off = cyc - m_g[k];
    int cs = cs_of(k);
    logic a = m_act[k];
    string s = $sformatf("[%0d] cyc %0d", k, cyc);
    chk({"gnt0", s}, 32'(o_gnt0[k]), 32'(a && off == 0 && !m_port[k]));
    chk({"gnt1", s}, 32'(o_gnt1[k]), 32'(a && off == 0 && m_port[k]));
    chk({"done0", s}, 32'(o_done0[k]), 32'(a && off == cs + 1 && !m_port[k]));
    chk({"done1", s}, 32'(o_done1[k]), 32'(a && off == cs + 1 && m_port[k]));
    chk({"ram_cs", s}, 32'(o_cs[k]), 32'(a && off >= 1 && off <= cs));
    chk({"busy", s}, 32'(o_busy[k]), 32'(a));
    chk({"ram_rw", s}, 32'(o_rw[k]), 32'(m_rw[k]));
    chk({"ram_addr", s}, 32'(o_addr[k]), 32'(m_addr[k]));
    chk({"ram_data_in", s}, 32'(o_din[k]), 32'(m_data[k]));
    chk({"rdata", s}, 32'(o_rdata[k]), 32'(m_rdata[k]));
  endtask
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (!reset) model_reset(k);
      else model_advance(k);
      compare(k);
    end
  endtask
  task automatic set0(input int k, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    req0_v[k] = r; rw0_v[k] = w; addr0_v[k] = a; wdata0_v[k] = d;
  endtask
  task automatic set1(input int k, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    req1_v[k] = r; rw1_v[k] = w; addr1_v[k] = a; wdata1_v[k] = d;
  endtask
  task automatic rnd(input int k);
    if (!req0_v[k] || gnt_now(k, 1'b0))
      set0(k, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
    if (!req1_v[k] || gnt_now(k, 1'b1))
      set1(k, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
  endtask
  int cs_cnt [4];
  int done_at [4];
  logic exp_g, p_rr;
  initial begin
    for (int k = 0; k < 4; k++) begin
      set0(k, 1'b0, 1'b1, 8'h00, 8'h00);
      set1(k, 1'b0, 1'b1, 8'h00, 8'h00);
      model_reset(k);
      for (int i = 0; i < 256; i++) m_mem[k][i] = 8'(i) ^ 8'h5A;
      cs_cnt[k] = 0;
      done_at[k] = -1;
    end
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    chk("reset rdata", 32'(o_rdata[0]), 32'h00);
    chk("reset ram_rw", 32'(o_rw[0]), 32'h1);
    // asynchronous reset in the middle of a strobe
    set0(0, 1'b1, 1'b0, 8'h44, 8'h99);
    cycle();
    chk("t1 gnt0", 32'(o_gnt0[0]), 32'h1);
    set0(0, 1'b0, 1'b0, 8'h44, 8'h99);
    cycle();
    chk("t1 cs before reset", 32'(o_cs[0]), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t1 cs async", 32'(o_cs[0]), 32'h0);
    chk("t1 busy async", 32'(o_busy[0]), 32'h0);
    chk("t1 gnt0 async", 32'(o_gnt0[0]), 32'h0);
    chk("t1 done0 async", 32'(o_done0[0]), 32'h0);
    for (int k = 0; k < 4; k++) model_reset(k);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (3) begin
      cycle();
      chk("t1 no done", 32'(o_done0[0]), 32'h0);
    end
    chk("t1 rdata", 32'(o_rdata[0]), 32'h00);
    // both requests held: round-robin alternates, fixed priority starves port 1
    for (int k = 0; k < 2; k++) begin
      set0(k, 1'b1, 1'b1, 8'h01, 8'h00);
      set1(k, 1'b1, 1'b1, 8'h02, 8'h00);
    end
    for (int t = 1; t <= 25; t++) begin
      cycle();
      exp_g = (t % 4 == 1) && t <= 21;
      p_rr = ((t - 1) / 4) % 2 == 1;
      chk($sformatf("t4 rr gnt0 t%0d", t), 32'(o_gnt0[0]), 32'(exp_g && !p_rr));
      chk($sformatf("t4 rr gnt1 t%0d", t), 32'(o_gnt1[0]), 32'(exp_g && p_rr));
      chk($sformatf("t4 fixed gnt0 t%0d", t), 32'(o_gnt0[1]), 32'(exp_g && t < 21));
      chk($sformatf("t4 fixed gnt1 t%0d", t), 32'(o_gnt1[1]), 32'(t == 21));
      if (t >= 16)
        for (int k = 0; k < 2; k++) begin
          if (gnt_now(k, 1'b0)) req0_v[k] = 1'b0;
          if (gnt_now(k, 1'b1)) req1_v[k] = 1'b0;
        end
    end
    // port 0 write then port 1 read of the same location
    set0(0, 1'b1, 1'b0, 8'h3C, 8'hA5);
    cycle();
    chk("t2 gnt0", 32'(o_gnt0[0]), 32'h1);
    chk("t2 cs setup", 32'(o_cs[0]), 32'h0);
    set0(0, 1'b0, 1'b0, 8'h3C, 8'hA5);
    repeat (2) begin
      cycle();
      chk("t2 cs", 32'(o_cs[0]), 32'h1);
      chk("t2 rw", 32'(o_rw[0]), 32'h0);
      chk("t2 addr", 32'(o_addr[0]), 32'h3C);
      chk("t2 din", 32'(o_din[0]), 32'hA5);
    end
    cycle();
    chk("t2 done0", 32'(o_done0[0]), 32'h1);
    chk("t2 cs hold", 32'(o_cs[0]), 32'h0);
    set1(0, 1'b1, 1'b1, 8'h3C, 8'h00);
    cycle();
    chk("t3 gnt1", 32'(o_gnt1[0]), 32'h1);
    set1(0, 1'b0, 1'b1, 8'h3C, 8'h00);
    repeat (2) begin
      cycle();
      chk("t3 rw", 32'(o_rw[0]), 32'h1);
    end
    cycle();
    chk("t3 done1", 32'(o_done1[0]), 32'h1);
    chk("t3 rdata", 32'(o_rdata[0]), 32'hA5);
    set0(0, 1'b1, 1'b0, 8'h3C, 8'h11);
    cycle();
    set0(0, 1'b0, 1'b0, 8'h3C, 8'h11);
    repeat (3) cycle();
    chk("t3 write done0", 32'(o_done0[0]), 32'h1);
    chk("t3 rdata kept", 32'(o_rdata[0]), 32'hA5);
    // inputs changed right after grant do not disturb the running access
    set0(0, 1'b1, 1'b0, 8'h10, 8'h33);
    cycle();
    chk("t5 gnt0", 32'(o_gnt0[0]), 32'h1);
    set0(0, 1'b0, 1'b1, 8'h20, 8'h44);
    repeat (3) begin
      cycle();
      chk("t5 addr", 32'(o_addr[0]), 32'h10);
      chk("t5 din", 32'(o_din[0]), 32'h33);
    end
    chk("t5 done0", 32'(o_done0[0]), 32'h1);
    // strobe length extremes
    set0(2, 1'b1, 1'b0, 8'h07, 8'h77);
    set0(3, 1'b1, 1'b0, 8'h07, 8'h77);
    for (int t = 1; t <= 20; t++) begin
      cycle();
      for (int k = 2; k < 4; k++) begin
        cs_cnt[k] += int'(o_cs[k]);
        if (o_done0[k] && done_at[k] < 0) done_at[k] = t;
        if (t == 1) req0_v[k] = 1'b0;
      end
    end
    chk("t6 cs width CS=1", 32'(cs_cnt[2]), 32'd1);
    chk("t6 cs width CS=15", 32'(cs_cnt[3]), 32'd15);
    chk("t6 done latency CS=1", 32'(done_at[2]), 32'd3);
    chk("t6 done latency CS=15", 32'(done_at[3]), 32'd17);
    // randomized traffic on all configurations
    repeat (600) begin
      cycle();
      for (int k = 0; k < 4; k++) rnd(k);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
